cnn_run_sequencer: RTL
======================

Name: cnn_run_sequencer

Overview:
- Synthesizable host-side initiator for the CNN accelerator's START/DONE protocol, so batch runs work on-chip without a simulation host.
- For each image index it soft-resets the accelerator, pulses START, waits for DONE, then reads the prediction word from SRAM address 0 via read port A.
- Compares the prediction against the golden label and accumulates pass/error counts.
- Sits beside `top`, sharing the TwoPort SRAM read port (port A is muxed to the sequencer whenever busy is high).

Parameters:
- RUN_TIMES, 200: number of images per batch (1..2^IMG_IDX_BITS).
- IMG_IDX_BITS, 8: width of the image index and of the counters.
- INTERNAL_BITS, 32: SRAM word width.
- SRAM_ADDR_BITS, 16: SRAM address width.
- TO_BITS, 26: width of the timeout counter.
- TIMEOUT_CYCLES, 48000000: maximum number of cycles spent in WAIT per image.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- go  in  1  single-cycle pulse that starts a batch
- acc_rst  out  1  soft reset to the accelerator
- acc_start  out  1  START pulse to the accelerator
- acc_done  in  1  DONE from the accelerator
- img_sel  out  IMG_IDX_BITS  current image index, driven to the image loader/ROM bank select
- exp_label  in  INTERNAL_BITS  golden prediction for img_sel; must be stable one cycle after img_sel changes
- SRAM_CENA  out  1  port A chip enable, active low
- SRAM_AA  out  SRAM_ADDR_BITS  port A address
- SRAM_QA  in  INTERNAL_BITS  port A read data, valid one cycle after the enabled edge
- busy  out  1  high from the cycle after go is accepted until FIN
- batch_done  out  1  single-cycle pulse at end of batch
- pass_cnt  out  IMG_IDX_BITS+1  number of matching images
- err_cnt  out  IMG_IDX_BITS+1  number of mismatches plus timeouts
- last_pred  out  INTERNAL_BITS  last captured prediction
- timeout  out  1  sticky flag; cleared by the next accepted go

Behaviour:
- Reset values:
  - all outputs 0, except SRAM_CENA=1.
  - state IDLE.
  - rst asserted mid-batch aborts the batch immediately; no batch_done is issued.
- IDLE:
  - go=1 → RST.
  - On acceptance: clear img_sel, pass_cnt, err_cnt and timeout.
  - go is ignored in every state except IDLE.
- RST: acc_rst=1 for exactly one cycle → STRT.
- STRT: acc_start=1 for exactly one cycle; clear the WAIT counter → WAIT.
- WAIT:
  - acc_done is sampled each cycle; acc_done=1 → READ.
  - If the counter reaches TIMEOUT_CYCLES-1 with acc_done=0: set timeout, err_cnt+1, → FIN (batch aborted).
  - If acc_done and the timeout boundary occur in the same cycle, acc_done wins.
- READ: SRAM_CENA=0 and SRAM_AA=0 for one cycle → CAP.
- CAP:
  - Capture SRAM_QA into last_pred.
  - Full-width compare with exp_label: equal → pass_cnt+1, else err_cnt+1.
  - Then → NXT.
- NXT:
  - If img_sel==RUN_TIMES-1 → FIN.
  - Else img_sel+1 → RST.
  - img_sel never wraps.
- FIN: batch_done=1 for one cycle → IDLE.
- Per-image latency: 5 cycles plus the accelerator's DONE delay.
- Invariant: pass_cnt+err_cnt equals the number of images completed.
- Outside READ, SRAM_CENA=1 and SRAM_AA=0.
- acc_done asserted outside WAIT is ignored.

Optional Feature:
- Macro: SEQ_FIRST_ERR_EN.
- When defined, three extra outputs exist:
  - first_err_valid (1 bit)
  - first_err_idx (IMG_IDX_BITS)
  - first_err_pred (INTERNAL_BITS)
- On the first CAP mismatch or timeout of a batch, they latch img_sel and SRAM_QA (0 on timeout) and set valid.
- Later errors do not overwrite them.
- They are cleared on rst and on the next accepted go.
- When undefined, these ports and registers are absent and all other behaviour is identical.

Test Plan:
- RUN_TIMES=3, accelerator model raises DONE 10 cycles after START, QA=label for all images → pass_cnt=3, err_cnt=0, batch_done once, exactly 3 acc_start pulses, img_sel ends at 2.
- QA=5 while exp_label=7 for image 1, other images match → err_cnt=1, pass_cnt=2, last_pred = image 2 value; with SEQ_FIRST_ERR_EN: first_err_idx=1, first_err_pred=5.
- TIMEOUT_CYCLES=20, DONE never asserted → timeout=1, err_cnt=1, pass_cnt=0, batch_done after 20 WAIT cycles, no SRAM_CENA low pulse.
- DONE asserted exactly on the last timeout cycle → treated as done: timeout=0, READ occurs.
- go pulsed again mid-batch, then rst asserted mid-WAIT → second go ignored; after rst all outputs are 0, SRAM_CENA=1, no batch_done.
- Check SRAM_CENA=0 with SRAM_AA=0 for exactly one cycle per image, and last_pred sampled on the following edge.

Source files
------------

// File: rtl/cnn_run_sequencer.sv
// cnn_run_sequencer: on-chip batch initiator for the accelerator START/DONE protocol with pass/error scoring.
// Optional first-error capture is enabled by defining SEQ_FIRST_ERR_EN.
module cnn_run_sequencer #(
    parameter int RUN_TIMES      = 200,
    parameter int IMG_IDX_BITS   = 8,
    parameter int INTERNAL_BITS  = 32,
    parameter int SRAM_ADDR_BITS = 16,
    parameter int TO_BITS        = 26,
    parameter int TIMEOUT_CYCLES = 48000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    output logic                      acc_rst,
    output logic                      acc_start,
    input  logic                      acc_done,
    output logic [IMG_IDX_BITS-1:0]   img_sel,
    input  logic [INTERNAL_BITS-1:0]  exp_label,
    output logic                      SRAM_CENA,
    output logic [SRAM_ADDR_BITS-1:0] SRAM_AA,
    input  logic [INTERNAL_BITS-1:0]  SRAM_QA,
    output logic                      busy,
    output logic                      batch_done,
    output logic [IMG_IDX_BITS:0]     pass_cnt,
    output logic [IMG_IDX_BITS:0]     err_cnt,
    output logic [INTERNAL_BITS-1:0]  last_pred,
    output logic                      timeout
`ifdef SEQ_FIRST_ERR_EN
   ,output logic                      first_err_valid,
    output logic [IMG_IDX_BITS-1:0]   first_err_idx,
    output logic [INTERNAL_BITS-1:0]  first_err_pred
`endif
);
    typedef enum logic [2:0] {IDLE, RST, STRT, WAIT, READ, CAP, NXT, FIN} state_t;

    localparam logic [IMG_IDX_BITS-1:0] IMG_LAST = IMG_IDX_BITS'(RUN_TIMES - 1);
    localparam logic [TO_BITS-1:0]      TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t state, nxt;
    logic [TO_BITS-1:0] wcnt;
    logic to_hit, miss;

    always_comb begin
        nxt        = state;
        acc_rst    = state == RST;
        acc_start  = state == STRT;
        SRAM_CENA  = state != READ;
        SRAM_AA    = '0;
        busy       = state != IDLE;
        batch_done = state == FIN;
        // DONE takes priority over the timeout boundary in the same cycle
        to_hit     = state == WAIT && !acc_done && wcnt == TO_LAST;
        miss       = state == CAP && SRAM_QA != exp_label;
        case (state)
            IDLE:    nxt = go ? RST : IDLE;
            RST:     nxt = STRT;
            STRT:    nxt = WAIT;
            WAIT:    nxt = acc_done ? READ : (to_hit ? FIN : WAIT);
            READ:    nxt = CAP;
            CAP:     nxt = NXT;
            NXT:     nxt = img_sel == IMG_LAST ? FIN : RST;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            img_sel   <= '0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            last_pred <= '0;
            timeout   <= 1'b0;
            wcnt      <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && go) begin
                img_sel  <= '0;
                pass_cnt <= '0;
                err_cnt  <= '0;
                timeout  <= 1'b0;
            end
            if (state == STRT) wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (to_hit) begin
                timeout <= 1'b1;
                err_cnt <= err_cnt + 1'b1;
            end
            if (state == CAP) begin
                last_pred <= SRAM_QA;
                if (miss) err_cnt <= err_cnt + 1'b1;
                else pass_cnt <= pass_cnt + 1'b1;
            end
            if (state == NXT && img_sel != IMG_LAST) img_sel <= img_sel + 1'b1;
        end
    end

`ifdef SEQ_FIRST_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && go)) begin
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_pred  <= '0;
        end else if ((to_hit || miss) && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= img_sel;
            first_err_pred  <= to_hit ? '0 : SRAM_QA;
        end
    end
`endif
endmodule
